mdu_seq: RTL and testbench

Multi-cycle sequencer for the EX-stage multiply/divide resource. It owns the HI/LO registers and accepts one operation per start pulse. For mult/div it holds busy for a fixed cycle budget, then commits HI/LO atomically. It serves mthi/mtlo in a single cycle, supports a flush-driven cancel, and drives the busy flag that the hazard unit uses to stall mfhi/mflo/mult/div in D.

---
 rtl/mdu_seq.sv | 117 +++++++++++
 tb/tb_mdu_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - EX-stage multiply/divide sequencer owning HI/LO
// Holds busy for a fixed cycle budget per mult/div, then commits HI/LO atomically.
module mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        rd_sel,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi, lo;
    logic        done_q;

    logic        accept, start_md, commit, signed_op, is_div, div_zero;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, uq, ur, quot, rem, res_hi, res_lo;

    assign accept   = start && !cancel && (state == IDLE);
    assign start_md = accept && !op[2];
    assign commit   = (state == RUN) && !cancel && (cnt == 4'd1);

    assign signed_op = !op_q[0];
    assign is_div    = op_q[1];
    assign div_zero  = (b_q == 32'd0);

    // Signed division is done on magnitudes so the INT_MIN / -1 corner
    // falls out naturally as 0x80000000 with a zero remainder.
    always_comb begin
        ext_a  = {{32{signed_op & a_q[31]}}, a_q};
        ext_b  = {{32{signed_op & b_q[31]}}, b_q};
        prod   = ext_a * ext_b;
        mag_a  = (signed_op && a_q[31]) ? (32'd0 - a_q) : a_q;
        mag_b  = (signed_op && b_q[31]) ? (32'd0 - b_q) : b_q;
        uq     = div_zero ? 32'd0 : (mag_a / mag_b);
        ur     = div_zero ? 32'd0 : (mag_a % mag_b);
        quot   = (signed_op && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
        rem    = (signed_op && a_q[31]) ? (32'd0 - ur) : ur;
        res_hi = is_div ? rem  : prod[63:32];
        res_lo = is_div ? quot : prod[31:0];
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start_md) begin
                    state_next = RUN;
                    cnt_next   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end
            end
            RUN: begin
                if (cancel || cnt == 4'd1) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            op_q   <= 3'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            done_q <= commit;
            if (start_md) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            if (commit && !(is_div && div_zero)) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (accept && op == OP_MTHI) hi <= a;
            if (accept && op == OP_MTLO) lo <= a;
        end
    end

    assign busy = (state == RUN);
    assign done = done_q;
    assign out  = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - randomized and directed bench for mdu_seq
// Reference HI/LO come from 64-bit arithmetic on the issued operands.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        rd_sel = 1'b0;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .rd_sel(rd_sel), .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        rd_sel = 1'b1; #1 h = out;
        rd_sel = 1'b0; #1 l = out;
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p, q, r;
        longint unsigned up;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd1: begin
                up = {32'd0, x} * {32'd0, y};
                hi_m = up[63:32]; lo_m = up[31:0];
            end
            3'd2: if (y != 0) begin
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
                hi_m = r[31:0]; lo_m = q[31:0];
            end
            3'd3: if (y != 0) begin
                hi_m = x % y; lo_m = x / y;
            end
            3'd4: hi_m = x;
            3'd5: lo_m = x;
            default: ;
        endcase
    endtask

    task automatic run_mdiv(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            input string tag);
        int nb, nd, first_d, bad, n;
        logic [31:0] h0, l0, h, l, hd, ld;
        read_hilo(h0, l0);
        model(o, x, y);
        n = o[1] ? 10 : 5;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        nb = 0; nd = 0; first_d = -1; bad = 0; hd = 32'hx; ld = 32'hx;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (busy) begin
                nb++;
                read_hilo(h, l);
                if (h !== h0 || l !== l0) bad++;
            end
            if (done) begin
                nd++;
                if (first_d < 0) begin
                    first_d = i;
                    read_hilo(hd, ld);
                end
            end
        end
        chk({tag, "_busy_cycles"}, nb, n);
        chk({tag, "_done_pulses"}, nd, 1);
        chk({tag, "_done_cycle"}, first_d, n);
        chk({tag, "_no_early_result"}, bad, 0);
        chk({tag, "_hi"}, hd, hi_m);
        chk({tag, "_lo"}, ld, lo_m);
    endtask

    task automatic run_single(input logic [2:0] o, input logic [31:0] x, input string tag);
        logic [31:0] h, l;
        model(o, x, 32'd0);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        read_hilo(h, l);
        chk({tag, "_hi"}, h, hi_m);
        chk({tag, "_lo"}, l, lo_m);
    endtask

    initial begin
        logic [31:0] h, l, h0, l0, x, y;
        logic [2:0]  o;
        int nb, nd;

        // Reset state
        repeat (2) @(negedge clk);
        read_hilo(h, l);
        chk("reset_hi", h, 32'h0);
        chk("reset_lo", l, 32'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        rst = 1'b1;

        // Directed arithmetic cases
        run_mdiv(3'd0, 32'hFFFFFFFD, 32'd7, "mult_neg");
        chk("mult_neg_hi_const", hi_m, 32'hFFFFFFFF);
        chk("mult_neg_lo_const", lo_m, 32'hFFFFFFEB);
        run_mdiv(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        run_mdiv(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
        chk("div_neg_lo_const", lo_m, 32'hFFFFFFFD);
        chk("div_neg_hi_const", hi_m, 32'hFFFFFFFF);
        run_mdiv(3'd3, 32'd7, 32'd0, "divu_zero");
        run_mdiv(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        chk("div_ovf_lo_const", lo_m, 32'h80000000);
        chk("div_ovf_hi_const", hi_m, 32'h0);

        // mthi then mtlo back to back; busy must never rise
        nb = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h12345678;
        @(negedge clk);
        if (busy) nb++;
        op = 3'd5; a = 32'h9ABCDEF0;
        @(negedge clk);
        if (busy) nb++;
        start = 1'b0;
        model(3'd4, 32'h12345678, 32'd0);
        model(3'd5, 32'h9ABCDEF0, 32'd0);
        read_hilo(h, l);
        chk("mtx_hi", h, 32'h12345678);
        chk("mtx_lo", l, 32'h9ABCDEF0);
        chk("mtx_busy", nb, 0);

        // Reserved op and cancel-in-IDLE must be ignored
        run_single(3'd6, 32'hDEADBEEF, "reserved");
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hCAFEF00D; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        read_hilo(h, l);
        chk("idle_cancel_hi", h, hi_m);
        chk("idle_cancel_busy", busy, 1'b0);

        // Cancel in busy cycle 3 with a start and operand churn during RUN
        read_hilo(h0, l0);
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); @(negedge clk);
        @(negedge clk);
        chk("cancel_busy_before", busy, 1'b1);
        cancel = 1'b1; start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        chk("cancel_busy_after", busy, 1'b0);
        nd = 0; nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        read_hilo(h, l);
        chk("cancel_done", nd, 0);
        chk("cancel_ignored_start", nb, 0);
        chk("cancel_hi", h, h0);
        chk("cancel_lo", l, l0);

        // Randomized mix
        for (int k = 0; k < 16; k++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (k % 4 == 1) x = $urandom_range(0, 1000);
            if (o <= 3'd3) run_mdiv(o, x, y, "rand_md");
            else run_single(o, x, "rand_single");
        end

        // Asynchronous reset in busy cycle 2 of a mult
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'h00012345; b = 32'h00067890;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        rd_sel = 1'b1; #0.1 h = out;
        rd_sel = 1'b0; #0.1 l = out;
        chk("arst_hi", h, 32'h0);
        chk("arst_lo", l, 32'h0);
        hi_m = 32'h0; lo_m = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("arst_discarded", nd, 0);
        run_mdiv(3'd1, 32'h0000FFFF, 32'h00010001, "post_reset_multu");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
